// File: rtl/rs_decode_sched_pkg.sv
// Shared types and constants for the RS decoder scheduler.
package rs_decode_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  localparam int CW_WORDS      = 50;
  localparam int CW_WORD_W     = 32;
  localparam int TIMEOUT_CNT_W = 13;

endpackage

// File: rtl/rs_decode_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner when en_i is high.
module rs_decode_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       en_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] ptr_q, ptr_d;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[IDW'((int'(ptr_q) + i) % NUM_REQ)]) begin
        gnt_idx_o = IDW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
    gnt_o[gnt_idx_o] = |req_i;
  end

  // Pointer advances to one past the winner, wrapping at NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (int'(gnt_idx_o) == NUM_REQ - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rs_decode_sched.sv
// Shares one RS decoder core among NUM_REQ requesters: round-robin grant,
// clear / decode_en sequencing, result capture and tagged response.
// Optional watchdog in WAIT: define RS_DECODE_SCHED_TIMEOUT_EN.
module rs_decode_sched
  import rs_decode_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CW_W        = CW_WORDS * CW_WORD_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*CW_W-1:0]    req_data_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [CW_W-1:0]            rsp_err_pos_o,
  output logic                       rsp_with_error_o,
  output logic                       rsp_timeout_o,
  output logic                       core_clrn_o,
  output logic                       core_decode_en_o,
  output logic [CW_W-1:0]            core_data_o,
  input  logic                       core_ready_i,
  input  logic                       core_output_valid_i,
  input  logic                       core_with_error_i,
  input  logic [CW_W-1:0]            core_error_pos_i,
  output logic                       busy_o
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("rs_decode_sched: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TIMEOUT_CNT_W)) begin : g_bad_timeout
    $error("rs_decode_sched: TIMEOUT_CYC does not fit the watchdog counter");
  end

  sched_state_e                   state_q, state_d;
  logic [CW_W-1:0]                data_q, data_d;
  logic [CW_W-1:0]                err_pos_q, err_pos_d;
  logic [IDW-1:0]                 id_q, id_d;
  logic                           with_err_q, with_err_d;
  logic                           timeout_q, timeout_d;
  logic [NUM_REQ-1:0]             gnt;
  logic [IDW-1:0]                 gnt_idx;
  logic                           accept;
  logic                           wd_fire;
  logic [NUM_REQ-1:0][CW_W-1:0]   req_data_a;

  assign req_data_a = req_data_i;
  // Reset gates the accept so no ready leaks out while rst_ni is low.
  assign accept     = rst_ni && (state_q == IDLE) && (|req_valid_i);

  rs_decode_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .en_i      (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

`ifdef RS_DECODE_SCHED_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Watchdog counts WAIT cycles; it sits at zero everywhere else so it is
  // already cleared when WAIT is entered.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == WAIT) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wd_cnt_q <= '0;
    else         wd_cnt_q <= wd_cnt_d;
  end

  assign wd_fire = (wd_cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYC - 1));
`else
  assign wd_fire = 1'b0;
`endif

  // Next state, captured data and per-state strobes.
  always_comb begin
    state_d          = state_q;
    data_d           = data_q;
    id_d             = id_q;
    err_pos_d        = err_pos_q;
    with_err_d       = with_err_q;
    timeout_d        = timeout_q;
    req_ready_o      = '0;
    core_clrn_o      = 1'b1;
    core_decode_en_o = 1'b0;
    rsp_valid_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready_o = gnt;
          data_d      = req_data_a[gnt_idx];
          id_d        = gnt_idx;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        core_clrn_o = 1'b0;
        state_d     = ISSUE;
      end
      ISSUE: begin
        if (core_ready_i) begin
          core_decode_en_o = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        // A real result beats a watchdog expiry in the same cycle.
        if (core_output_valid_i) begin
          err_pos_d  = core_error_pos_i;
          with_err_d = core_with_error_i;
          timeout_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_fire) begin
          err_pos_d  = '0;
          with_err_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      data_q     <= '0;
      id_q       <= '0;
      err_pos_q  <= '0;
      with_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      id_q       <= id_d;
      err_pos_q  <= err_pos_d;
      with_err_q <= with_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign core_data_o      = data_q;
  assign rsp_id_o         = id_q;
  assign rsp_err_pos_o    = err_pos_q;
  assign rsp_with_error_o = with_err_q;
  assign rsp_timeout_o    = timeout_q;
  assign busy_o           = (state_q != IDLE);

  // Requesters still waiting for their ready at the last edge.
  logic [NUM_REQ-1:0] pend_q, pend_d;

  // Pending = valid but not yet granted this cycle.
  always_comb begin
    pend_d = req_valid_i & ~req_ready_o;
  end

  // Pending register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  // A requester may not withdraw valid before it has been granted.
  a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pend_q & ~req_valid_i) == '0);

endmodule
